// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU's architectural register file.
package cpu_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int REG_COUNT  = 32;
  localparam int ZERO_REG   = 31;

  typedef logic [4:0]           reg_addr_t;
  typedef logic [REG_COUNT-1:0] row_en_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_64x32_if.sv
// Register-file bus: write-back write port plus two read ports.
// No handshake: a write is taken on every rising edge with RegWrite=1, reads are combinational.
interface regfile_64x32_if;
  import cpu_pkg::*;

  logic      RegWrite;
  reg_addr_t WriteRegister;
  reg_data_t WriteData;
  reg_addr_t ReadRegister1;
  reg_addr_t ReadRegister2;
  reg_data_t ReadData1;
  reg_data_t ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_64x32_wr_row_decode.sv
// Expands the write address into a one-hot row enable gated by the write enable.
module wr_row_decode
  import cpu_pkg::*;
(
  input  reg_addr_t addr_i,
  input  logic      en_i,
  output row_en_t   row_en_o
);

  // The zero register never gets a row enable, so it neither stores nor bypasses.
  always_comb begin
    row_en_o = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if ((i != ZERO_REG) && en_i && (addr_i == reg_addr_t'(i))) begin
        row_en_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_64x32.sv
// 32 x 64-bit register file: X31 reads zero, two combinational read ports with
// same-cycle write bypass, one synchronous write port, synchronous reset.
module regfile_64x32
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  regfile_64x32_if.slave        rf
);

  reg_data_t regs_q [REG_COUNT-1];
  reg_data_t regs_d [REG_COUNT-1];
  row_en_t   row_en;

  wr_row_decode u_wr_row_decode (
    .addr_i   (rf.WriteRegister),
    .en_i     (rf.RegWrite),
    .row_en_o (row_en)
  );

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < REG_COUNT - 1; i++) begin
      if (row_en[i]) begin
        regs_d[i] = rf.WriteData;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_COUNT - 1; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reset overrides bypass; row_en already excludes X31, so X31 never bypasses.
  always_comb begin
    rf.ReadData1 = '0;
    if (!reset && (rf.ReadRegister1 != reg_addr_t'(ZERO_REG))) begin
      if (row_en[rf.ReadRegister1]) begin
        rf.ReadData1 = rf.WriteData;
      end else begin
        rf.ReadData1 = regs_q[rf.ReadRegister1];
      end
    end
  end

  always_comb begin
    rf.ReadData2 = '0;
    if (!reset && (rf.ReadRegister2 != reg_addr_t'(ZERO_REG))) begin
      if (row_en[rf.ReadRegister2]) begin
        rf.ReadData2 = rf.WriteData;
      end else begin
        rf.ReadData2 = regs_q[rf.ReadRegister2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_64x32.sv
// Bench for regfile_64x32: directed vector table, address sweep and a randomized
// phase checked against a behavioural register model.
module tb_regfile_64x32;
  import cpu_pkg::*;

  typedef struct {
    logic      rst;
    logic      we;
    reg_addr_t wa;
    reg_data_t wd;
    reg_addr_t ra1;
    reg_addr_t ra2;
    reg_data_t e1;
    reg_data_t e2;
  } vec_t;

  logic clk;
  logic reset;
  regfile_64x32_if rf ();

  regfile_64x32 dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf.slave)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard
  logic [DATA_WIDTH-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];
  reg_data_t model [REG_COUNT];

  function automatic vec_t mk(input logic rst, input logic we, input reg_addr_t wa,
                              input reg_data_t wd, input reg_addr_t ra1,
                              input reg_addr_t ra2, input reg_data_t e1,
                              input reg_data_t e2);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
    v.ra1 = ra1; v.ra2 = ra2; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input reg_data_t act);
    reg_data_t exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: queue empty, actual %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: actual %h required %h", name, act, exp);
      end
    end
  endtask

  // Drive one cycle; outputs sampled on the falling edge, before the write edge.
  task automatic drive_cycle(input vec_t v, input string name);
    reset            = v.rst;
    rf.RegWrite      = v.we;
    rf.WriteRegister = v.wa;
    rf.WriteData     = v.wd;
    rf.ReadRegister1 = v.ra1;
    rf.ReadRegister2 = v.ra2;
    exp_q.push_back(v.e1);
    exp_q.push_back(v.e2);
    @(negedge clk);
    check($sformatf("%s rd1[x%0d]", name, v.ra1), rf.ReadData1);
    check($sformatf("%s rd2[x%0d]", name, v.ra2), rf.ReadData2);
    @(posedge clk);
    #1;
  endtask

  function automatic reg_data_t model_read(input logic rst, input logic we,
                                           input reg_addr_t wa, input reg_data_t wd,
                                           input reg_addr_t ra);
    if (rst || ra == 5'd31) return '0;
    if (we && wa == ra) return wd;
    return model[ra];
  endfunction

  initial begin
    vec_t v;
    reset = 1'b0;
    rf.RegWrite = 1'b0;
    rf.WriteRegister = '0;
    rf.WriteData = '0;
    rf.ReadRegister1 = '0;
    rf.ReadRegister2 = '0;
    #1;

    // Reset then read every address on both ports.
    drive_cycle(mk(1, 0, 0, 0, 0, 31, 0, 0), "reset");
    for (int a = 0; a < 32; a++) begin
      drive_cycle(mk(0, 0, 0, 0, reg_addr_t'(a), reg_addr_t'(31 - a), 0, 0), "sweep");
    end

    // Directed table: one entry per cycle.
    vecs.push_back(mk(0, 1, 5, 64'h0123_4567_89AB_CDEF, 5, 4, 64'h0123_4567_89AB_CDEF, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5, 5, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF));
    vecs.push_back(mk(0, 0, 0, 0, 4, 6, 0, 0));
    vecs.push_back(mk(0, 1, 7, 64'hDEAD_BEEF, 7, 5, 64'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF));
    vecs.push_back(mk(0, 0, 0, 0, 7, 7, 64'hDEAD_BEEF, 64'hDEAD_BEEF));
    vecs.push_back(mk(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 31, 5, 0, 64'h0123_4567_89AB_CDEF));
    vecs.push_back(mk(0, 0, 0, 0, 7, 30, 64'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 1, 3, 64'h11, 0, 3, 0, 64'h11));
    vecs.push_back(mk(0, 0, 3, 64'h55, 3, 3, 64'h11, 64'h11));
    vecs.push_back(mk(0, 0, 0, 0, 3, 3, 64'h11, 64'h11));
    vecs.push_back(mk(0, 1, 2, 64'h22, 2, 0, 64'h22, 0));
    vecs.push_back(mk(0, 1, 2, 64'h33, 2, 2, 64'h33, 64'h33));
    vecs.push_back(mk(0, 1, 2, 64'h44, 2, 3, 64'h44, 64'h11));
    vecs.push_back(mk(0, 0, 0, 0, 2, 2, 64'h44, 64'h44));
    vecs.push_back(mk(1, 1, 2, 64'h99, 2, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 3, 0, 0));
    foreach (vecs[i]) begin
      drive_cycle(vecs[i], $sformatf("vec%0d", i));
    end

    // Randomized phase against the model; state is all zero after the last reset.
    for (int r = 0; r < REG_COUNT; r++) model[r] = '0;
    for (int n = 0; n < 300; n++) begin
      v.rst = ($urandom_range(0, 19) == 0);
      v.we  = ($urandom_range(0, 3) != 0);
      v.wa  = reg_addr_t'($urandom_range(0, 31));
      v.wd  = {$urandom, $urandom};
      v.ra1 = ($urandom_range(0, 2) == 0) ? v.wa : reg_addr_t'($urandom_range(0, 31));
      v.ra2 = reg_addr_t'($urandom_range(0, 31));
      v.e1  = model_read(v.rst, v.we, v.wa, v.wd, v.ra1);
      v.e2  = model_read(v.rst, v.we, v.wa, v.wd, v.ra2);
      drive_cycle(v, "rand");
      if (v.rst) begin
        for (int r = 0; r < REG_COUNT; r++) model[r] = '0;
      end else if (v.we && v.wa != 5'd31) begin
        model[v.wa] = v.wd;
      end
    end

    // Final report
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: actual %0d queued required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
